uart_tx_fifo: RTL and testbench

//  Byte FIFO in front of the UART transmitter; host/bus side pushes bytes, transmitter pops them.

---
 rtl/uart_tx_fifo_pkg.sv | 32 +++
 rtl/uart_fifo_mem.sv | 46 ++++
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared types and helpers for the UART transmit FIFO.
//
// Contents:
//   fifo_op_e       - which operations are actually performed on an edge
//                     (push, pop, both or neither) after the full/empty
//                     qualification has been applied.
//   fifo_op_decode  - maps the qualified push/pop pair to a fifo_op_e.
// -----------------------------------------------------------------------------
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_POP  = 2'b01,
        FIFO_OP_PUSH = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

    // Decode the accepted push/pop pair into the operation performed this edge.
    function automatic fifo_op_e fifo_op_decode(input logic push, input logic pop);
        fifo_op_e op;
        case ({push, pop})
            2'b10:   op = FIFO_OP_PUSH;
            2'b01:   op = FIFO_OP_POP;
            2'b11:   op = FIFO_OP_BOTH;
            default: op = FIFO_OP_IDLE;
        endcase
        return op;
    endfunction

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x DATA_W register array backing the UART transmit FIFO.
// One synchronous write port and one asynchronous (combinational) read port.
// The array is deliberately not reset: the control logic in uart_tx_fifo never
// exposes an entry that has not been written since reset.
//
// Parameters:
//   DATA_W  - word width
//   DEPTH   - number of entries
//   ADDR_W  - address width, $clog2(DEPTH)
//
// Ports:
//   clk    in   1       write clock (posedge)
//   we     in   1       write enable
//   waddr  in   ADDR_W  write address
//   wdata  in   DATA_W  write data
//   raddr  in   ADDR_W  read address
//   rdata  out  DATA_W  mem[raddr], combinational
// -----------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Synchronous write port; storage carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Asynchronous read port: DEPTH is a power of two so raddr is always in range.
    assign rdata = mem_r[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// First-word-fall-through byte FIFO in front of the UART transmitter.
// The host pushes bytes with wrEn; the transmitter's registered one-cycle
// txDone pulse drives rdEn and pops the head. The head byte is presented on
// dataOut whenever empty=0 so the transmitter can latch it while idle.
//
// Parameters (defaults come from `UART_DATA_W / `TXFIFO_DEPTH, normally
// supplied by the shared UartStates.v include; 8 / 8 if not defined):
//   DATA_W  - byte width, must match the transmitter
//   DEPTH   - number of entries, power of two, >= 2
//   ADDR_W  - pointer width, $clog2(DEPTH)
//
// Ports:
//   clk        in   1         system clock, all state on posedge
//   reset      in   1         asynchronous, active-high, clears all state
//   wrEn       in   1         push dataIn this cycle
//   dataIn     in   DATA_W    byte to push
//   rdEn       in   1         pop head (transmitter txDone)
//   dataOut    out  DATA_W    head byte, 0 while empty
//   empty      out  1         no entries stored
//   full       out  1         count == DEPTH
//   count      out  ADDR_W+1  occupancy 0..DEPTH
//   overflow   out  1         sticky, write dropped while full   (macro only)
//   underflow  out  1         sticky, pop requested while empty  (macro only)
//
// Configuration:
//   UART_TXFIFO_ERR_FLAGS_EN - when defined, adds the sticky overflow and
//   underflow outputs. When undefined those ports do not exist and dropped
//   writes / empty pops are silently ignored.
// -----------------------------------------------------------------------------
`ifndef UART_DATA_W
`define UART_DATA_W 8
`endif
`ifndef TXFIFO_DEPTH
`define TXFIFO_DEPTH 8
`endif

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = `UART_DATA_W,
    parameter int DEPTH  = `TXFIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              rdEn,
    output logic [DATA_W-1:0] dataOut,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
`ifdef UART_TXFIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    // Architectural state
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              empty_r;
    logic              full_r;

    // Next-state and qualified controls
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [ADDR_W-1:0] rd_ptr_nxt_s;
    logic [ADDR_W:0]   count_nxt_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    fifo_op_e          op_s;
    logic [DATA_W-1:0] head_s;

    // Qualify requests and compute next pointers/count from the performed operation.
    always_comb begin
        // A pop frees a slot on the same edge, so a push into a full FIFO is
        // accepted when it coincides with a pop. Full implies non-empty
        // (DEPTH >= 2), so that pop is always genuine.
        push_ok_s    = wrEn & (~full_r | rdEn);
        // In the empty case a simultaneous push cannot be popped: there is
        // no bypass from dataIn to the head.
        pop_ok_s     = rdEn & ~empty_r;
        op_s         = fifo_op_decode(push_ok_s, pop_ok_s);
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        case (op_s)
            FIFO_OP_PUSH: begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                count_nxt_s  = count_r + CNT_ONE;
            end
            FIFO_OP_POP: begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                count_nxt_s  = count_r - CNT_ONE;
            end
            FIFO_OP_BOTH: begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                count_nxt_s  = count_r;
            end
            FIFO_OP_IDLE: begin
                count_nxt_s  = count_r;
            end
            default: begin
                count_nxt_s  = count_r;
            end
        endcase
    end

    // Pointer, occupancy and status registers; flags follow next-state count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == CNT_ZERO);
            full_r   <= (count_nxt_s == DEPTH_CNT);
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (wr_ptr_r),
        .wdata (dataIn),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Head byte is masked while empty so stale or never-written entries never leak.
    always_comb begin
        if (empty_r) begin
            dataOut = {DATA_W{1'b0}};
        end else begin
            dataOut = head_s;
        end
    end

    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;

`ifdef UART_TXFIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;
    logic overflow_set_s;
    logic underflow_set_s;

    // A write is dropped only when full without a coinciding pop; a pop
    // request is an underflow only when empty and no push accompanies it.
    always_comb begin
        overflow_set_s  = wrEn & full_r & ~rdEn;
        underflow_set_s = rdEn & empty_r & ~wrEn;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end
            if (underflow_set_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Scoreboard bench for uart_tx_fifo at DEPTH=8. Directed stimulus pushes the
// byte it expects to read back into exp_q when issuing an accepted write; a
// monitor on the falling edge tracks expected occupancy, checks count/empty/
// full every cycle and pops exp_q to compare dataOut whenever a pop occurs.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wrEn;
    logic [DATA_W-1:0] dataIn;
    logic              rdEn;
    logic [DATA_W-1:0] dataOut;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
`ifdef UART_TXFIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    int errors = 0;
    int checks = 0;
    int m_count = 0;
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wrEn     (wrEn),
        .dataIn   (dataIn),
        .rdEn     (rdEn),
        .dataOut  (dataOut),
        .empty    (empty),
        .full     (full),
        .count    (count)
`ifdef UART_TXFIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; record accepted bytes.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic acc);
        @(posedge clk);
        #1;
        wrEn   = w;
        dataIn = d;
        rdEn   = r;
        if (w && acc) exp_q.push_back(d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: compares visible state with the model, then advances the model
    // with the inputs that the next rising edge will apply.
    always @(negedge clk) begin
        logic push_ok;
        logic pop_ok;
        if (reset) begin
            m_count = 0;
        end else begin
            check("count", 32'(count), 32'(m_count));
            check("empty", 32'(empty), 32'(m_count == 0));
            check("full", 32'(full), 32'(m_count == DEPTH));
            if (m_count == 0) check("dataOut_when_empty", 32'(dataOut), 32'h0);
            pop_ok  = rdEn && (m_count > 0);
            push_ok = wrEn && ((m_count < DEPTH) || rdEn);
            if (pop_ok) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_data: DUT popped %0h, required no pop (scoreboard empty)", dataOut);
                end else begin
                    check("pop_data", 32'(dataOut), 32'(exp_q.pop_front()));
                end
            end
            m_count = m_count + int'(push_ok) - int'(pop_ok);
        end
    end

    initial begin
        reset  = 1'b1;
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        dataIn = 8'h00;
        #2;
        check("reset_count", 32'(count), 32'h0);
        check("reset_empty", 32'(empty), 32'h1);
        check("reset_full", 32'(full), 32'h0);
        check("reset_dataOut", 32'(dataOut), 32'h0);
        #10;
        reset = 1'b0;

        // Basic order: A5, 3C, FF out in order, empty again afterwards.
        drive(1'b1, 8'hA5, 1'b0, 1'b1);
        drive(1'b1, 8'h3C, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Fill past capacity: ninth write dropped, drain returns 00..07.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(i), 1'b0, (i < 8));
        idle(1);
`ifdef UART_TXFIFO_ERR_FLAGS_EN
        check("overflow_set", 32'(overflow), 32'h1);
`endif
        for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);

        // Full with head 10: simultaneous push 77 / pop keeps count at 8.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        idle(1);
        check("full_wr_rd_count", 32'(count), 32'h8);
        check("full_wr_rd_head", 32'(dataOut), 32'h11);
        for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);

        // Empty with simultaneous push 5A / pop: push only.
        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        idle(1);
        check("empty_wr_rd_head", 32'(dataOut), 32'h5A);
`ifdef UART_TXFIFO_ERR_FLAGS_EN
        check("underflow_clear", 32'(underflow), 32'h0);
`endif
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
`ifdef UART_TXFIFO_ERR_FLAGS_EN
        check("underflow_set", 32'(underflow), 32'h1);
`endif

        // Wrap: 20 bytes streamed at occupancy 3, pointers wrap twice.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
        for (int i = 3; i < 20; i++) drive(1'b1, 8'(i), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);

        // Asynchronous reset mid-cycle discards stored bytes immediately.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
        idle(1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_count", 32'(count), 32'h0);
        check("async_reset_empty", 32'(empty), 32'h1);
        check("async_reset_full", 32'(full), 32'h0);
`ifdef UART_TXFIFO_ERR_FLAGS_EN
        check("async_reset_overflow", 32'(overflow), 32'h0);
        check("async_reset_underflow", 32'(underflow), 32'h0);
`endif
        exp_q.delete();
        #2;
        reset = 1'b0;
        drive(1'b1, 8'hC3, 1'b0, 1'b1);
        idle(1);
        check("post_reset_head", 32'(dataOut), 32'hC3);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_fifo
